reg_writeback_unit: RTL

//  Write side of the integer register bank. Takes result writebacks from the ALU and from the load unit,

---
 rtl/rv_pkg.sv | 17 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/reg_writeback_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared register-file definitions for the integer writeback path.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        reg_onehot = NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: two pushes (port 0 older) and one pop per cycle, with every
// entry exposed so the owner can build busy/forwarding views of queued results.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push0,
    input  wb_entry_t                     i_entry0,
    input  logic                          i_push1,
    input  wb_entry_t                     i_entry1,
    input  logic                          i_pop,
    output wb_entry_t                     o_head,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [$clog2(DEPTH)-1:0]      o_rd_ptr,
    output logic [DEPTH-1:0]              o_valid,
    output wb_entry_t [DEPTH-1:0]         o_entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH-1:0]      r_valid;
    wb_entry_t [DEPTH-1:0] r_mem;

    logic [PTR_W-1:0]      w_wr_idx1;
    logic                  w_pop;

    // The second push lands behind the first when both fire together.
    assign w_wr_idx1 = r_wr_ptr + PTR_W'(i_push0);
    assign w_pop     = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push0) begin
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (i_push1) begin
                r_valid[w_wr_idx1] <= 1'b1;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
            r_count  <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(w_pop);
        end
    end

    // Payload storage needs no reset: r_valid qualifies every entry.
    always_ff @(posedge clk) begin
        if (i_push0) begin
            r_mem[r_wr_ptr] <= i_entry0;
        end
        if (i_push1) begin
            r_mem[w_wr_idx1] <= i_entry1;
        end
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_valid   = r_valid;
    assign o_entries = r_mem;

endmodule

// File: rtl/reg_writeback_unit.sv
// Write side of the integer register bank: queues ALU/load results, drains one write per
// cycle, and exposes queued results to decode (busy mask) and operand forwarding.
module reg_writeback_unit
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_wb_valid,
    output logic                    ld_wb_ready,
    input  logic [REG_ADDR_W-1:0]   ld_wb_rd,
    input  logic [XLEN-1:0]         ld_wb_data,
    input  logic                    alu_wb_valid,
    output logic                    alu_wb_ready,
    input  logic [REG_ADDR_W-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0]         alu_wb_data,
    output logic                    rf_wr_en,
    output logic [REG_ADDR_W-1:0]   rf_wr_addr,
    output logic [XLEN-1:0]         rf_wr_data,
    output logic [NUM_REGS-1:0]     busy_mask,
    input  logic [REG_ADDR_W-1:0]   fwd_addr_a,
    output logic                    fwd_hit_a,
    output logic [XLEN-1:0]         fwd_data_a,
    input  logic [REG_ADDR_W-1:0]   fwd_addr_b,
    output logic                    fwd_hit_b,
    output logic [XLEN-1:0]         fwd_data_b,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]      w_count;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [DEPTH-1:0]      w_valid;
    wb_entry_t [DEPTH-1:0] w_entries;
    wb_entry_t             w_head;
    wb_entry_t             w_ld_entry;
    wb_entry_t             w_alu_entry;
    logic                  w_push_ld;
    logic                  w_push_alu;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   w_busy;

    // Readies look only at the registered count; the ALU port keeps one slot for the load.
    assign ld_wb_ready  = !rst && (w_count <= CNT_W'(DEPTH - 1));
    assign alu_wb_ready = !rst && (w_count <= CNT_W'(DEPTH - 2));

    // Writes to x0 complete the handshake but are dropped.
    assign w_push_ld  = ld_wb_valid  && ld_wb_ready  && (ld_wb_rd  != '0);
    assign w_push_alu = alu_wb_valid && alu_wb_ready && (alu_wb_rd != '0);

    assign w_ld_entry.rd    = ld_wb_rd;
    assign w_ld_entry.data  = ld_wb_data;
    assign w_alu_entry.rd   = alu_wb_rd;
    assign w_alu_entry.data = alu_wb_data;

    // The bank does not see rst, so the write strobe is suppressed here.
    assign w_pop      = (w_count != '0) && !rst;
    assign rf_wr_en   = w_pop;
    assign rf_wr_addr = w_head.rd;
    assign rf_wr_data = w_head.data;
    assign fifo_count = w_count;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push0   (w_push_ld),
        .i_entry0  (w_ld_entry),
        .i_push1   (w_push_alu),
        .i_entry1  (w_alu_entry),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_rd_ptr  (w_rd_ptr),
        .o_valid   (w_valid),
        .o_entries (w_entries)
    );

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_valid[i]) begin
                w_busy = w_busy | reg_onehot(w_entries[i].rd);
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy_mask = w_busy;

    // Walk oldest to youngest so the last match is the value decode should see.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = w_rd_ptr + PTR_W'(k);
            if (w_valid[idx] && (fwd_addr_a != '0) && (w_entries[idx].rd == fwd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = w_entries[idx].data;
            end
            if (w_valid[idx] && (fwd_addr_b != '0) && (w_entries[idx].rd == fwd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = w_entries[idx].data;
            end
        end
    end

endmodule
